// File: rtl/key_debounce.sv
// key_debounce: debounces one raw push-button and derives press/release
// pulses, a long-press level and auto-repeat pulses from the clean level.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 2_000_000,
  parameter int unsigned LONG_CYC     = 100_000_000,
  parameter int unsigned REPEAT_CYC   = 20_000_000,
  parameter int unsigned ACTIVE_HIGH  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  // Each counter only has to reach its parameter minus one.
  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned HW = (LONG_CYC     > 1) ? $clog2(LONG_CYC)     : 1;
  localparam int unsigned RW = (REPEAT_CYC   > 1) ? $clog2(REPEAT_CYC)   : 1;

  localparam logic [CW-1:0] LAST_DB   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] LAST_LONG = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] LAST_REP  = RW'(REPEAT_CYC - 1);

  // Pressed always reads 1 after this inversion.
  localparam logic INV = (ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  state_t        state;
  logic          sync_a;
  logic          s;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;

  // Two-flop synchronizer on the polarity-normalized pin; resets to not-pressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= key_in ^ INV;
      s      <= sync_a;
    end
  end

  // Debounce state machine with registered level, pulse and long-press outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_CHK;
            cnt   <= CW'(1);
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state <= IDLE;
          end else if (cnt == LAST_DB) begin
            state     <= HELD;
            key_level <= 1'b1;
            key_press <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE_CHK;
            cnt   <= CW'(1);
          end
          // Hold/repeat timing still advances on the cycle that leaves HELD;
          // only the RELEASE_CHK cycles themselves are frozen.
          if (!key_long) begin
            if (hold_cnt == LAST_LONG) begin
              key_long   <= 1'b1;
              key_repeat <= 1'b1;
              rep_cnt    <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end else if (rep_cnt == LAST_REP) begin
            key_repeat <= 1'b1;
            rep_cnt    <= '0;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
          end
        end
        RELEASE_CHK: begin
          if (s) begin
            state <= HELD;
          end else if (cnt == LAST_DB) begin
            state       <= IDLE;
            key_level   <= 1'b0;
            key_long    <= 1'b0;
            key_release <= 1'b1;
            cnt         <= '0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: one active-high and one active-low
// instance see the same logical button and must match the same expectations.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic key;
  logic key_n;

  logic level_a, press_a, release_a, long_a, repeat_a;
  logic level_b, press_b, release_b, long_b, repeat_b;
  logic [4:0] obs_a;
  logic [4:0] obs_b;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int          n        = 0;

  logic bpat [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20),
    .REPEAT_CYC  (8),
    .ACTIVE_HIGH (1)
  ) dut_hi (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key),
    .key_level  (level_a),
    .key_press  (press_a),
    .key_release(release_a),
    .key_long   (long_a),
    .key_repeat (repeat_a)
  );

  key_debounce #(
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20),
    .REPEAT_CYC  (8),
    .ACTIVE_HIGH (0)
  ) dut_lo (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_n),
    .key_level  (level_b),
    .key_press  (press_b),
    .key_release(release_b),
    .key_long   (long_b),
    .key_repeat (repeat_b)
  );

  assign obs_a = {level_a, press_a, release_a, long_a, repeat_a};
  assign obs_b = {level_b, press_b, release_b, long_b, repeat_b};

  // Output vectors are {level, press, release, long, repeat}.
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b expected=%b", tag, n, got, exp);
    end
  endtask

  task automatic compare(input string tag, input logic [4:0] exp);
    check({tag, "/hi"}, obs_a, exp);
    check({tag, "/lo"}, obs_b, exp);
  endtask

  task automatic drive(input logic v);
    key   = v;
    key_n = ~v;
  endtask

  // Advance one clock; outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1);
    tick();
    tick();
    compare("reset", 5'b00000);
    drive(1'b0);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      compare("idle", 5'b00000);
    end

    // Clean press: first high sample at edge 10, first low sample at edge 30.
    n = 0;
    while (n < 45) begin
      drive((n + 1 >= 10) && (n + 1 < 30));
      tick();
      compare("clean", {(n >= 15) && (n < 35), n == 15, n == 35, 1'b0, 1'b0});
    end

    // Bounce: 1,1,1,0,1,1,0 then low; never accepted.
    n = 0;
    while (n < 20) begin
      drive((n + 1 <= 7) ? bpat[n] : 1'b0);
      tick();
      compare("bounce", 5'b00000);
    end

    // Long press: press accepted at edge 6, released with first low sample at 67.
    n = 0;
    while (n < 80) begin
      drive(n + 1 <= 66);
      tick();
      compare("long", {(n >= 6) && (n < 72), n == 6, n == 72, (n >= 26) && (n < 72),
                       (n >= 26) && (n <= 66) && ((n - 26) % 8 == 0)});
    end

    // Two-sample glitch at edges 36,37 during long press: repeat slips 42 -> 44.
    n = 0;
    while (n < 80) begin
      drive((n + 1 <= 66) && (n + 1 != 36) && (n + 1 != 37));
      tick();
      compare("glitch", {(n >= 6) && (n < 72), n == 6, n == 72, (n >= 26) && (n < 72),
                         n == 26 || n == 34 || n == 44 || n == 52 || n == 60 || n == 68});
    end

    // Reset sampled at edge 31 while long-held; key stays down, R = 32.
    n = 0;
    while (n < 45) begin
      drive(1'b1);
      rst_n = (n + 1 == 31) ? 1'b0 : 1'b1;
      tick();
      compare("rst_hold", {((n >= 6) && (n <= 30)) || (n >= 37), n == 6 || n == 37, 1'b0,
                           (n >= 26) && (n <= 30), n == 26});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces one raw mechanical push-button for the music player front panel. It produces a clean debounced level that feeds the rising-edge pulse stage, plus its own press/release pulses, a long-press flag and auto-repeat pulses. These drive song skip, volume and fast-seek controls. One instance is used per button.

## Interface
- `DEBOUNCE_CYC`, default 2_000_000: consecutive stable cycles needed to accept a change (20 ms at 100 MHz); must be ≥ 2.
- `LONG_CYC`, default 100_000_000: cycles after `key_press` before `key_long` asserts (1 s).
- `REPEAT_CYC`, default 20_000_000: period of `key_repeat` pulses while long-held (200 ms).
- `ACTIVE_HIGH`, default 1: 1 means a pressed button reads 1; 0 means `key_in` is inverted on entry.
- `clk` input 1: system clock, single clock domain.
- `rst_n` input 1: synchronous, active-low reset.
- `key_in` input 1: raw button pin, asynchronous and bouncing.
- `key_level` output 1: debounced pressed level, 1 while pressed.
- `key_press` output 1: one-cycle pulse when a press is accepted.
- `key_release` output 1: one-cycle pulse when a release is accepted.
- `key_long` output 1: level; high from long-press detection until the release is accepted.
- `key_repeat` output 1: one-cycle pulses during a long press.

## Operation
- **Input path**
  - `key_in` is XORed with `~ACTIVE_HIGH`, then passes through a 2-flop synchronizer; the synchronizer output is `s`.
  - Both synchronizer flops reset to the not-pressed value (0 after normalization).
- **State machine:** IDLE, PRESS_CHK, HELD, RELEASE_CHK. A debounce counter `cnt` is sized by `DEBOUNCE_CYC`.
- **IDLE**
  - If `s`=1: go to PRESS_CHK with `cnt`<=1 (this sample counts).
- **PRESS_CHK**
  - If `s`=0: return to IDLE (bounce rejected, no output).
  - If `s`=1 and `cnt`==`DEBOUNCE_CYC`-1: go to HELD, `key_level`<=1, pulse `key_press`, `hold_cnt`<=0.
  - Otherwise `cnt`++.
- **HELD**
  - If `s`=0: go to RELEASE_CHK with `cnt`<=1.
  - Before long detection (`key_long`=0): if `hold_cnt`==`LONG_CYC`-1, then `key_long`<=1, pulse `key_repeat`, `rep_cnt`<=0; otherwise `hold_cnt`++.
  - After long detection (`key_long`=1): if `rep_cnt`==`REPEAT_CYC`-1, pulse `key_repeat` and `rep_cnt`<=0; otherwise `rep_cnt`++.
- **RELEASE_CHK**
  - `hold_cnt` and `rep_cnt` are frozen; no `key_repeat` pulses are issued.
  - If `s`=1: return to HELD; counting resumes from the frozen values.
  - If `s`=0 and `cnt`==`DEBOUNCE_CYC`-1: go to IDLE; `key_level`<=0, `key_long`<=0, pulse `key_release`; clear all counters.
  - Otherwise `cnt`++.
- **Counter widths:** each counter is wide enough for its parameter minus 1. Counters never wrap; each compare-and-clear happens before overflow.
- **Output relationships**
  - `key_press` and `key_release` are never high in the same cycle.
  - `key_repeat` is only ever high while `key_long`=1.
  - The first `key_repeat` pulse is coincident with the rising edge of `key_long`.

## Timing
- All outputs are registered.
- **Reset:** every output = 0, state = IDLE, all counters = 0, synchronizer flops = inactive.
- **Press latency:** let edge E0 be the first edge that samples `key_in` pressed, with `key_in` held stable afterwards. `key_level` rises and `key_press` pulses after edge E0+`DEBOUNCE_CYC`+1.
- **Release latency:** identical, measured from the first sample of the released value.
- **Long press:** `key_long` rises, together with the first `key_repeat`, exactly `LONG_CYC` cycles after the `key_press` cycle.
- **Auto-repeat:** later `key_repeat` pulses are spaced exactly `REPEAT_CYC` cycles apart, plus any cycles spent in RELEASE_CHK.
- **Reset mid-operation:** `rst_n` sampled low forces the reset state on that edge, with no `key_release` pulse. A button still held after reset is re-detected as a fresh press with the full press latency.

## Test plan
Parameters for all tests: `DEBOUNCE_CYC`=4, `LONG_CYC`=20, `REPEAT_CYC`=8, `ACTIVE_HIGH`=1.
- **Clean press:** `key_in` first sampled high at edge 10 and held to edge 30, then low.
  - `key_press` is high for the one cycle after edge 15; `key_level` is high from edge 15.
  - `key_release` pulses after edge 35; `key_level` is low from edge 35.
- **Bounce rejection:** `key_in` pattern 1,1,1,0,1,1,0, then 0 throughout.
  - `key_press`, `key_level` and `key_long` all stay 0.
- **Long press:** press accepted at cycle P, held for 60 cycles.
  - `key_long` is high from P+20.
  - `key_repeat` pulses at P+20, P+28, P+36, P+44, ...
- **Release glitch during long press:** 2-cycle low glitch on `key_in` at P+30.
  - `key_long` stays 1 and no `key_release` pulse occurs.
  - The next `key_repeat` slips from P+36 to P+38.
- **Reset mid-hold:** `rst_n` low for 1 cycle while in HELD with `key_long`=1; `key_in` kept high.
  - All outputs are 0 on the next cycle.
  - The first edge with `rst_n` high is edge R; a new `key_press` pulses after edge R+5.
- **Inverted polarity:** repeat the clean-press test with `ACTIVE_HIGH`=0 and `key_in` driven inverted.
  - Outputs match the clean-press test cycle for cycle.
